// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU with memory wait-state timeout.
// Optional retired-instruction counter is enabled by defining SEQ_RETIRE_COUNT_EN.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       imem_ready,
    output logic       imem_req,
    output logic       ir_load,
    input  logic [6:0] opcode,
    input  logic       data_read_en,
    input  logic       data_write_en,
    input  logic       reg_write_en,
    input  logic       beq,
    input  logic       bne,
    input  logic       jump,
    input  logic       alu_zero,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic [2:0] state,
    output logic       err
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    // state  | meaning
    // IDLE   | waiting for run
    // FETCH  | instruction request outstanding, ir_load on imem_ready
    // DECODE | one quiet cycle for control-unit decode to settle
    // EXEC   | branch/jump retire, or dispatch to MEM / WB
    // MEM    | data access outstanding; store retires on dmem_ready
    // WB     | register write and PC advance
    // HALT   | memory timeout; only reset leaves
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t               state_q;
    state_t               state_d;
    state_t               next_instr;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 wait_at_limit;
    logic                 mem_op;
    logic                 ctl_op;
    logic                 br_taken;
    logic                 waiting;

    // opcode is carried for debug visibility only; sequencing relies on decode strobes
    logic unused_opcode;
    assign unused_opcode = ^opcode;

    assign state         = state_q;
    assign mem_op        = data_read_en | data_write_en;
    assign ctl_op        = beq | bne | jump;
    assign br_taken      = (beq & alu_zero) | (bne & ~alu_zero);
    assign next_instr    = run ? S_FETCH : S_IDLE;
    assign wait_at_limit = (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));
    assign waiting       = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_at_limit) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mem_op) begin
                    state_d = S_MEM;
                end else if (ctl_op) begin
                    pc_en   = 1'b1;
                    pc_sel  = jump ? 2'b10 : (br_taken ? 2'b01 : 2'b00);
                    state_d = next_instr;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = data_write_en;
                if (dmem_ready) begin
                    if (data_write_en) begin
                        pc_en   = 1'b1;
                        state_d = next_instr;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_at_limit) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                rf_we   = reg_write_en;
                pc_en   = 1'b1;
                state_d = next_instr;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // any state change restarts the wait counter, which covers every entry to FETCH and MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            end
            if (state_d == S_HALT) err <= 1'b1;
        end
    end

`ifdef SEQ_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (pc_en) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector tables, model-built corner sequences,
// and randomized instruction streams expanded cycle by cycle from the sequencing rules.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, imem_ready, dmem_ready;
    logic       data_read_en, data_write_en, reg_write_en, beq, bne, jump, alu_zero;
    logic [6:0] opcode;
    logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, err;
    logic [1:0] pc_sel;
    logic [2:0] state;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] instr_count;
`endif

    cpu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .ir_load      (ir_load),
        .opcode       (opcode),
        .data_read_en (data_read_en),
        .data_write_en(data_write_en),
        .reg_write_en (reg_write_en),
        .beq          (beq),
        .bne          (bne),
        .jump         (jump),
        .alu_zero     (alu_zero),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .state        (state),
        .err          (err)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    always #5 clk = ~clk;

    // in: run imem_ready dmem_ready rd wr rw beq bne jmp zero
    // ex: state[2:0] imem_req ir_load dmem_req dmem_we rf_we pc_en pc_sel[1:0] err
    typedef struct packed {
        logic [9:0]  in;
        logic [11:0] ex;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_count = 0;
    int   vec_no = 0;
    logic d_rd, d_wr, d_rw, d_beq, d_bne, d_jmp, d_zero;
    vec_t q[$];

    function automatic logic [11:0] ex_of(input int st, input bit ireq, input bit irl, input bit dreq,
                                          input bit dwe, input bit rfw, input bit pce, input int sel,
                                          input bit e);
        return {3'(st), ireq, irl, dreq, dwe, rfw, pce, 2'(sel), e};
    endfunction

    function automatic vec_t mk(input logic [9:0] in, input logic [11:0] ex);
        vec_t v;
        v.in = in;
        v.ex = ex;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {state, imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel, err};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        {run, imem_ready, dmem_ready, data_read_en, data_write_en, reg_write_en,
         beq, bne, jump, alu_zero} = t.in;
        opcode = 7'($urandom_range(0, 127));
        #2;
        check($sformatf("%s#%0d", nm, vec_no), 32'(outs()), 32'(t.ex));
        vec_no++;
        if (t.ex[3]) exp_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {run, imem_ready, dmem_ready, data_read_en, data_write_en, reg_write_en,
         beq, bne, jump, alu_zero} = '0;
        @(posedge clk);
        #1;
        check("reset", 32'(outs()), 32'(0));
        exp_count = 0;
        rst_n = 1'b1;
    endtask

    task automatic push(input bit r, input bit imr, input bit dmr, input logic [11:0] ex);
        q.push_back(mk({r, imr, dmr, d_rd, d_wr, d_rw, d_beq, d_bne, d_jmp, d_zero}, ex));
    endtask

    task automatic play(input string nm);
        while (q.size() > 0) apply(q.pop_front(), nm);
    endtask

    // expand one instruction (run held 1) into expected cycles; fw/mw = wait cycles before ready
    task automatic gen_instr(input int fw, input int mw, output bit halted);
        bit rdy;
        int sel;
        halted = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy = (i == fw);
            push(1, rdy, 0, ex_of(1, 1, rdy, 0, 0, 0, 0, 0, 0));
            if (rdy) break;
        end
        if (fw >= 16) begin
            halted = 1'b1;
            return;
        end
        push(1, 0, 0, ex_of(2, 0, 0, 0, 0, 0, 0, 0, 0));
        if (d_rd | d_wr) begin
            push(1, 0, 0, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < 16; i++) begin
                rdy = (i == mw);
                push(1, 0, rdy, ex_of(4, 0, 0, 1, d_wr, 0, rdy & d_wr, 0, 0));
                if (rdy) break;
            end
            if (mw >= 16) begin
                halted = 1'b1;
                return;
            end
            if (!d_wr) push(1, 0, 0, ex_of(5, 0, 0, 0, 0, d_rw, 1, 0, 0));
        end else if (d_beq | d_bne | d_jmp) begin
            sel = d_jmp ? 2 : (((d_beq & d_zero) | (d_bne & ~d_zero)) ? 1 : 0);
            push(1, 0, 0, ex_of(3, 0, 0, 0, 0, 0, 1, sel, 0));
        end else begin
            push(1, 0, 0, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0));
            push(1, 0, 0, ex_of(5, 0, 0, 0, 0, d_rw, 1, 0, 0));
        end
    endtask

    task automatic halt_tail();
        for (int i = 0; i < 4; i++) push(1'(i), 1, 1, ex_of(6, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic set_decode(input bit rd, input bit wr, input bit rw, input bit bq, input bit bn,
                              input bit jp, input bit z);
        {d_rd, d_wr, d_rw, d_beq, d_bne, d_jmp, d_zero} = {rd, wr, rw, bq, bn, jp, z};
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 24));
        if (r == 0) return 16;
        if (r < 6) return int'($urandom_range(1, 15));
        return 0;
    endfunction

    vec_t tbl_add[9];
    vec_t tbl_rundrop[9];

    initial begin
        bit h;
        int k;
        tbl_add = '{
            mk(10'b1110010000, ex_of(0, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(1, 1, 1, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(2, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(5, 0, 0, 0, 0, 1, 1, 0, 0)),
            mk(10'b1110010000, ex_of(1, 1, 1, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(2, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1110010000, ex_of(5, 0, 0, 0, 0, 1, 1, 0, 0))
        };
        tbl_rundrop = '{
            mk(10'b1000100000, ex_of(0, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1100100000, ex_of(1, 1, 1, 0, 0, 0, 0, 0, 0)),
            mk(10'b1000100000, ex_of(2, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1000100000, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b1000100000, ex_of(4, 0, 0, 1, 1, 0, 0, 0, 0)),
            mk(10'b0000100000, ex_of(4, 0, 0, 1, 1, 0, 0, 0, 0)),
            mk(10'b0010100000, ex_of(4, 0, 0, 1, 1, 0, 1, 0, 0)),
            mk(10'b0000100000, ex_of(0, 0, 0, 0, 0, 0, 0, 0, 0)),
            mk(10'b0000100000, ex_of(0, 0, 0, 0, 0, 0, 0, 0, 0))
        };
        opcode = '0;

        do_reset();
        for (int i = 0; i < 9; i++) apply(tbl_add[i], "add_tbl");

        do_reset();
        for (int i = 0; i < 9; i++) apply(tbl_rundrop[i], "st_rundrop");

        // load with three wait states, then taken and untaken BEQ
        do_reset();
        set_decode(1, 0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 12'b0);
        gen_instr(0, 3, h);
        set_decode(0, 0, 1, 1, 0, 0, 1);
        gen_instr(0, 0, h);
        set_decode(0, 0, 1, 1, 0, 0, 0);
        gen_instr(2, 0, h);
        play("ld_beq");

        // store timeout: 16 MEM cycles then HALT regardless of run
        do_reset();
        set_decode(0, 1, 0, 0, 0, 0, 0);
        push(1, 0, 0, 12'b0);
        gen_instr(0, 16, h);
        check("st_timeout_halted", 32'(h), 32'(1));
        for (int i = 0; i < 4; i++) push(1'(i), 0, 0, ex_of(6, 0, 0, 0, 0, 0, 0, 0, 1));
        play("st_timeout");
        do_reset();

        // ready arriving on the last tolerated wait cycle is accepted
        set_decode(0, 0, 1, 0, 0, 1, 0);
        push(1, 0, 0, 12'b0);
        gen_instr(15, 0, h);
        set_decode(1, 1, 0, 0, 1, 0, 1);
        gen_instr(0, 15, h);
        play("edge_wait");

        // asynchronous reset in the middle of a data access
        do_reset();
        set_decode(1, 0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 12'b0);
        push(1, 1, 0, ex_of(1, 1, 1, 0, 0, 0, 0, 0, 0));
        push(1, 0, 0, ex_of(2, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1, 0, 0, ex_of(3, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1, 0, 0, ex_of(4, 0, 0, 1, 0, 0, 0, 0, 0));
        play("mid_mem");
        #1;
        check("mid_mem_req", 32'({state, dmem_req}), 32'({3'd4, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("mid_mem_rst", 32'(outs()), 32'(0));
        @(posedge clk);
        #1;

        // randomized instruction stream
        do_reset();
        push(1, 0, 0, 12'b0);
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 3));
            set_decode(0, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 1'($urandom_range(0, 1)));
            case (k)
                1: begin
                    d_rd = 1'b1;
                    {d_beq, d_bne, d_jmp} = 3'($urandom_range(0, 7));
                end
                2: begin
                    d_wr = 1'b1;
                    d_rd = 1'($urandom_range(0, 1));
                    {d_beq, d_bne, d_jmp} = 3'($urandom_range(0, 7));
                end
                3: begin
                    case ($urandom_range(0, 2))
                        0: d_beq = 1'b1;
                        1: d_bne = 1'b1;
                        default: d_jmp = 1'b1;
                    endcase
                end
                default: ;
            endcase
            gen_instr(pick_wait(), pick_wait(), h);
            if (h) halt_tail();
            play("rand");
            if (h) begin
                do_reset();
                push(1, 0, 0, 12'b0);
            end
        end
        play("rand");

`ifdef SEQ_RETIRE_COUNT_EN
        check("instr_count", 32'(instr_count), 32'(16'(exp_count)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
